// File: rtl/dcache_if_arb2_if.sv
// dcache_if request/response bundle shared by LSU pipes, the arbiter and the memory-side slave.
// master drives requests and receives responses; slave does the opposite.
interface dcache_if_arb2_if;
    logic [31:0] addr;
    logic [31:0] data_wr;
    logic        rd;
    logic [3:0]  wr;
    logic        cacheable;
    logic        invalidate;
    logic        writeback;
    logic        flush;
    logic [10:0] req_tag;
    logic        accept;
    logic        ack;
    logic        error;
    logic [31:0] data_rd;
    logic [10:0] resp_tag;

    modport master (
        output addr, data_wr, rd, wr, cacheable, invalidate, writeback, flush, req_tag,
        input  accept, ack, error, data_rd, resp_tag
    );

    modport slave (
        input  addr, data_wr, rd, wr, cacheable, invalidate, writeback, flush, req_tag,
        output accept, ack, error, data_rd, resp_tag
    );
endinterface

// File: rtl/dcache_if_arb2.sv
// Two-master dcache_if arbiter: round-robin grant held until accepted, with an in-order
// route FIFO steering each slave response back to the master that issued it.
module dcache_if_arb2 #(
    parameter int OUTSTANDING = 2,
    parameter int ID_PTR_W    = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    dcache_if_arb2_if.slave         m0,
    dcache_if_arb2_if.slave         m1,
    dcache_if_arb2_if.master        mem
);
    logic                req0, req1;
    logic                rr_q;          // master preferred on the next tie (the one not served last)
    logic                lock_q, locked_id_q;
    logic                grant_valid, grant_id;
    logic                fifo_full, fifo_empty;
    logic                presented, push, pop;
    logic                head_id, ack0, ack1;
    logic                route_q [OUTSTANDING];
    logic [ID_PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ID_PTR_W:0]   count_q;

    assign req0 = m0.rd | (|m0.wr) | m0.invalidate | m0.writeback | m0.flush;
    assign req1 = m1.rd | (|m1.wr) | m1.invalidate | m1.writeback | m1.flush;

    assign fifo_full  = (count_q == (ID_PTR_W+1)'(OUTSTANDING));
    assign fifo_empty = (count_q == '0);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = req1 & ~req0;
        if (lock_q) begin
            grant_valid = 1'b1;
            grant_id    = locked_id_q;
        end else if (req0 & req1) begin
            grant_id = rr_q;
        end
    end

    assign presented = grant_valid & ~fifo_full;
    assign push      = presented & mem.accept;
    assign pop       = mem.ack & ~fifo_empty;
    assign head_id   = route_q[rd_ptr_q];

    // Slave request bus: granted master's fields, all zero when nothing is presented.
    assign mem.addr       = presented ? (grant_id ? m1.addr       : m0.addr)       : '0;
    assign mem.data_wr    = presented ? (grant_id ? m1.data_wr    : m0.data_wr)    : '0;
    assign mem.rd         = presented & (grant_id ? m1.rd         : m0.rd);
    assign mem.wr         = presented ? (grant_id ? m1.wr         : m0.wr)         : '0;
    assign mem.cacheable  = presented & (grant_id ? m1.cacheable  : m0.cacheable);
    assign mem.invalidate = presented & (grant_id ? m1.invalidate : m0.invalidate);
    assign mem.writeback  = presented & (grant_id ? m1.writeback  : m0.writeback);
    assign mem.flush      = presented & (grant_id ? m1.flush      : m0.flush);
    assign mem.req_tag    = presented ? (grant_id ? m1.req_tag    : m0.req_tag)    : '0;

    assign m0.accept = push & ~grant_id;
    assign m1.accept = push &  grant_id;

    // Responses go only to the route FIFO head; an ack with nothing outstanding is dropped.
    assign ack0 = pop & ~head_id;
    assign ack1 = pop &  head_id;

    assign m0.ack      = ack0;
    assign m0.error    = ack0 & mem.error;
    assign m0.data_rd  = ack0 ? mem.data_rd  : '0;
    assign m0.resp_tag = ack0 ? mem.resp_tag : '0;
    assign m1.ack      = ack1;
    assign m1.error    = ack1 & mem.error;
    assign m1.data_rd  = ack1 ? mem.data_rd  : '0;
    assign m1.resp_tag = ack1 ? mem.resp_tag : '0;

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q        <= 1'b0;
            lock_q      <= 1'b0;
            locked_id_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            if (push) begin
                rr_q   <= ~grant_id;
                lock_q <= 1'b0;
            end else if (presented) begin
                lock_q      <= 1'b1;
                locked_id_q <= grant_id;
            end

            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;

            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: route storage is not reset; entries are only read between push and pop,
    // and reset clears the pointers and count that qualify them.
    always_ff @(posedge clk_i) begin
        if (push) route_q[wr_ptr_q] <= grant_id;
    end
endmodule
